// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and default width for the bit serializer
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shift register with load priority over shift
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_shifted;

  // Vacated positions fill with zero so the register drains to all-zero.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
      assign serial_out = sr_q[WIDTH-1];
    end else begin : g_lsb
      assign sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
      assign serial_out = sr_q[0];
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = sr_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - word-to-bit serializer with one-word holding buffer and gapless back-to-back output
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hb_q, hb_d;
  logic             hb_full_q, hb_full_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_bit_q, last_bit_d;

  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic             sr_shift;
  logic             xfer;
  logic             in_last;

  assign load_ready = ~hb_full_q;
  assign xfer       = load_valid & ~hb_full_q;
  assign in_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hb_d      = hb_q;
    hb_full_d = hb_full_q;
    sr_load   = 1'b0;
    sr_data   = '0;
    sr_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          sr_load = 1'b1;
          sr_data = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!in_last) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (xfer) begin
            hb_d      = data_in;
            hb_full_d = 1'b1;
          end
        end else if (hb_full_q) begin
          sr_load   = 1'b1;
          sr_data   = hb_q;
          hb_full_d = 1'b0;
          cnt_d     = '0;
        end else if (xfer) begin
          sr_load = 1'b1;
          sr_data = data_in;
          cnt_d   = '0;
        end else begin
          // Load zeros so dout rests low while idle.
          sr_load = 1'b1;
          sr_data = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dout_valid_d = (state_d == SHIFT);
    last_bit_d   = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hb_q         <= '0;
      hb_full_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hb_q         <= hb_d;
      hb_full_q    <= hb_full_d;
      dout_valid_q <= dout_valid_d;
      last_bit_q   <= last_bit_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign last_bit   = last_bit_q;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .reset      (reset),
    .load       (sr_load),
    .load_data  (sr_data),
    .shift_en   (sr_shift),
    .serial_out (dout)
  );

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed and random checks of bit_serializer against a word-queue model
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid_m, load_valid_l;
  logic       load_ready_m, dout_m, dout_valid_m, last_bit_m;
  logic       load_ready_l, dout_l, dout_valid_l, last_bit_l;

  int checks = 0;
  int passed = 0;

  // Model: per instance, the list of words accepted but not yet fully sent, and the bit index of the head word.
  logic [7:0] mw [2][2];
  int         mcnt [2];
  int         mpos [2];

  logic [15:0] cap_m, cap_l;
  int          vcount_m;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid_m),
    .load_ready (load_ready_m),
    .dout       (dout_m),
    .dout_valid (dout_valid_m),
    .last_bit   (last_bit_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid_l),
    .load_ready (load_ready_l),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .last_bit   (last_bit_l)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input int i, input logic v, input logic [7:0] d, input logic rst);
    bit acc;
    acc = !rst && v && (mcnt[i] < 2);
    if (rst) begin
      mcnt[i] = 0;
      mpos[i] = 0;
    end else begin
      if (mcnt[i] > 0) begin
        mpos[i]++;
        if (mpos[i] == 8) begin
          mw[i][0] = mw[i][1];
          mcnt[i]--;
          mpos[i] = 0;
        end
      end
      if (acc) begin
        mw[i][mcnt[i]] = d;
        mcnt[i]++;
      end
    end
  endtask

  function automatic logic exp_dout(input int i);
    logic [7:0] w;
    if (mcnt[i] == 0) return 1'b0;
    w = mw[i][0];
    return (i == 0) ? w[7 - mpos[i]] : w[mpos[i]];
  endfunction

  task automatic step(input logic vm, input logic vl, input logic [7:0] d, input logic rst);
    load_valid_m = vm;
    load_valid_l = vl;
    data_in      = d;
    reset        = rst;
    @(posedge clk);
    model_edge(0, vm, d, rst);
    model_edge(1, vl, d, rst);
    #1;
    check("m_valid", dout_valid_m, mcnt[0] > 0);
    check("m_dout",  dout_m,       exp_dout(0));
    check("m_last",  last_bit_m,   (mcnt[0] > 0) && (mpos[0] == 7));
    check("m_ready", load_ready_m, mcnt[0] < 2);
    check("l_valid", dout_valid_l, mcnt[1] > 0);
    check("l_dout",  dout_l,       exp_dout(1));
    check("l_last",  last_bit_l,   (mcnt[1] > 0) && (mpos[1] == 7));
    check("l_ready", load_ready_l, mcnt[1] < 2);
    if (dout_valid_m) begin
      cap_m = {cap_m[14:0], dout_m};
      vcount_m++;
    end
    if (dout_valid_l) cap_l = {cap_l[14:0], dout_l};
  endtask

  initial begin
    logic [7:0] w [3];
    int k, acc_edge, ready_low;

    mcnt[0] = 0; mcnt[1] = 0; mpos[0] = 0; mpos[1] = 0;
    load_valid_m = 1'b0; load_valid_l = 1'b0; data_in = '0; reset = 1'b1;
    cap_m = '0; cap_l = '0; vcount_m = 0;

    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    check("reset_ready", load_ready_m, 1'b1);
    check("reset_valid", dout_valid_m, 1'b0);

    // Single word MSB-first.
    cap_m = '0; vcount_m = 0;
    step(1, 0, 8'h90, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 0);
    check_int("single_bits", int'(cap_m), 16'h0090);
    check_int("single_count", vcount_m, 8);

    // Single word LSB-first.
    cap_l = '0;
    step(0, 1, 8'h09, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 0);
    check_int("lsb_bits", int'(cap_l), 16'h0090);

    // Back-to-back words.
    cap_m = '0; vcount_m = 0;
    step(1, 0, 8'h99, 0);
    step(1, 0, 8'h0F, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 8'h00, 0);
    check_int("b2b_bits", int'(cap_m), 16'h990F);
    check_int("b2b_count", vcount_m, 16);

    // Backpressure: third word waits for the holding buffer to drain.
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    k = 0; acc_edge = -1; ready_low = 0;
    for (int e = 0; e < 30 && k < 3; e++) begin
      if (load_ready_m && k == 2) acc_edge = e;
      if (load_ready_m) begin
        step(1, 0, w[k], 0);
        k++;
      end else begin
        step(1, 0, w[k], 0);
      end
      if (!load_ready_m && k < 3) ready_low++;
    end
    check_int("bp_third_edge", acc_edge, 9);
    check_int("bp_ready_low", ready_low, 7);
    for (int i = 0; i < 30; i++) step(0, 0, 8'h00, 0);

    // Reset mid-word with the holding buffer full.
    step(1, 0, 8'hA5, 0);
    step(1, 0, 8'($urandom), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    check("mid_bit4_valid", dout_valid_m, 1'b1);
    check("mid_hb_full", load_ready_m, 1'b0);
    step(0, 0, 8'h00, 1);
    check("mid_rst_valid", dout_valid_m, 1'b0);
    check("mid_rst_ready", load_ready_m, 1'b1);
    vcount_m = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);
    check_int("mid_no_bits", vcount_m, 0);

    // Reset with a simultaneous transfer.
    step(1, 1, 8'hFF, 1);
    check("rst_xfer_valid", dout_valid_m, 1'b0);
    step(0, 0, 8'h00, 0);
    check("rst_xfer_idle", dout_valid_m, 1'b0);
    step(1, 0, 8'h5A, 0);
    check("fresh_accept", dout_valid_m, 1'b1);
    check("fresh_bit0", dout_m, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port data_in, input, WIDTH bits, the parallel word offered for serialization.
REQ-006 SHALL have port load_valid, input, 1 bit, meaning data_in holds a word to transfer.
REQ-007 SHALL have port load_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-008 SHALL have port dout, output, 1 bit, the serial bit stream (drives a downstream sequence detector din).
REQ-009 SHALL have port dout_valid, output, 1 bit, meaning dout carries a data bit this cycle.
REQ-010 SHALL have port last_bit, output, 1 bit, high during the final bit of each word.

Function
REQ-011 SHALL transfer a word on any rising edge where load_valid and load_ready are both 1; no other edge transfers.
REQ-012 SHALL hold two storage stages: shift register (SR) plus counter, and a one-word holding buffer (HB) with full flag.
REQ-013 SHALL drive load_ready = NOT hb_full, from registered state only, with no combinational path from load_valid.
REQ-014 SHALL use FSM states IDLE (SR empty) and SHIFT (SR emitting).
REQ-015 SHALL, in IDLE on a transfer, load the word directly into SR, clear the counter, go to SHIFT, and present the first bit on dout in the following cycle.
REQ-016 SHALL, in SHIFT, emit one bit per cycle for exactly WIDTH cycles with dout_valid=1, and assert last_bit=1 only in cycle WIDTH.
REQ-017 SHALL, in SHIFT on a transfer while not in the last-bit cycle, write the word into HB and set hb_full.
REQ-018 SHALL, at the last-bit-cycle edge with hb_full=1, move HB into SR, clear hb_full, and stay in SHIFT, leaving no idle gap between words.
REQ-019 SHALL, at the last-bit-cycle edge with hb_full=0 and a transfer, load the word directly into SR and stay in SHIFT with no gap.
REQ-020 SHALL, at the last-bit-cycle edge with hb_full=0 and no transfer, return to IDLE.
REQ-021 SHALL, in IDLE, drive dout=0, dout_valid=0 and last_bit=0.
REQ-022 SHALL make dout, dout_valid and last_bit registered outputs.
REQ-023 SHALL size the bit counter at clog2(WIDTH) bits and keep it from wrapping past WIDTH-1.
REQ-024 SHALL ignore data_in whenever load_valid=0 or load_ready=0.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, force IDLE, clear SR, counter and HB, set hb_full=0, dout=0, dout_valid=0, last_bit=0, load_ready=1.
REQ-026 SHALL, when reset is asserted mid-word, discard both the in-flight word and the buffered word, and emit no partial bits afterwards.
REQ-027 SHALL make reset take priority over a simultaneous transfer, which is not accepted.

Structure
REQ-028 SHALL place the state encodings (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant in the shared package serializer_pkg.
REQ-029 SHALL contain exactly one sub-module, piso_shift_reg (parallel load, shift enable, MSB_FIRST parameter); the FSM, HB and handshake stay in bit_serializer.

Verification
REQ-030 SHALL verify single word: word 8'h90 (MSB_FIRST=1) -> dout 1,0,0,1,0,0,0,0 over 8 cycles after the accept, dout_valid high for 8 cycles, last_bit only on the 8th, then IDLE.
REQ-031 SHALL verify back-to-back: 8'h99 then 8'h0F held valid -> 16 contiguous dout_valid cycles, bits 10011001 00001111, no gap.
REQ-032 SHALL verify backpressure: three words offered consecutively -> third accepted only after HB drains at the first word's last-bit edge; load_ready low in between.
REQ-033 SHALL verify reset mid-word: reset in bit 4 of 8'hA5 with HB full -> next cycle IDLE, dout_valid=0, load_ready=1, neither word emitted.
REQ-034 SHALL verify LSB-first: MSB_FIRST=0, word 8'h09 -> dout 1,0,0,1,0,0,0,0.
REQ-035 SHALL verify reset with a simultaneous transfer: load_valid=1 at the reset edge -> word not accepted, first post-reset bit appears only after a fresh accept.
